// File: rtl/mult_seq_ctrl_if.sv
// Request/response bundle for the sequential multiplier: start/ready/done handshake,
// operands in, registered product out.
interface mult_seq_ctrl_if #(
    parameter int WIDTH = 4
);
    logic                   start;
    logic [WIDTH-1:0]       X;
    logic [WIDTH-1:0]       Y;
    logic                   ready;
    logic                   done;
    logic [2*WIDTH-1:0]     P;

    modport master (output start, output X, output Y, input ready, input done, input P);
    modport slave  (input start, input X, input Y, output ready, output done, output P);
endinterface

// File: rtl/mult_seq_ctrl.sv
// Shift-and-add WIDTH x WIDTH unsigned multiplier sharing one adder over WIDTH steps.
// Optional MULT_EARLY_EXIT_EN finishes as soon as the remaining multiplier bits are zero.
module mult_seq_ctrl #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 3
) (
    input  logic            clk,
    input  logic            rst_b,
    mult_seq_ctrl_if.slave  bus
);
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t                 state_q, state_d;
    logic [WIDTH-1:0]       acc_q, acc_d;
    logic [WIDTH-1:0]       mcand_q, mcand_d;
    logic [WIDTH-1:0]       mplier_q, mplier_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [2*WIDTH-1:0]     p_q, p_d;
    logic                   ready_q, ready_d;
    logic                   done_q, done_d;

    logic [WIDTH-1:0]       addend_s;
    logic [WIDTH:0]         sum_s;
    logic [WIDTH-1:0]       acc_step_s;
    logic [WIDTH-1:0]       mplier_step_s;
    logic [CNT_W-1:0]       cnt_step_s;
    logic [2*WIDTH-1:0]     full_s;
    logic [2*WIDTH-1:0]     result_s;
    logic                   finish_s;
`ifdef MULT_EARLY_EXIT_EN
    logic [WIDTH-1:0]       rem_s;
    logic [CNT_W:0]         shamt_s;
`endif

    // One add-and-shift step: {carry, sum, mplier} shifted right by one bit.
    always_comb begin
        addend_s      = mplier_q[0] ? mcand_q : '0;
        sum_s         = {1'b0, acc_q} + {1'b0, addend_s};
        acc_step_s    = sum_s[WIDTH:1];
        mplier_step_s = {sum_s[0], mplier_q[WIDTH-1:1]};
        cnt_step_s    = cnt_q + CNT_W'(1);
        full_s        = {acc_step_s, mplier_step_s};
    end

`ifdef MULT_EARLY_EXIT_EN
    // Unconsumed multiplier bits sit in the low WIDTH-cnt bits of mplier; once zero,
    // the partial product is final and only needs realigning.
    always_comb begin
        rem_s    = mplier_step_s << cnt_step_s;
        shamt_s  = (CNT_W+1)'(WIDTH) - {1'b0, cnt_step_s};
        finish_s = (cnt_step_s == CNT_W'(WIDTH)) || (rem_s == '0);
        result_s = full_s >> shamt_s;
    end
`else
    // Fixed-latency completion after exactly WIDTH steps.
    always_comb begin
        finish_s = (cnt_step_s == CNT_W'(WIDTH));
        result_s = full_s;
    end
`endif

    // Next-state, datapath loads and registered handshake outputs.
    always_comb begin
        state_d  = state_q;
        acc_d    = acc_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        cnt_d    = cnt_q;
        p_d      = p_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    mcand_d  = bus.X;
                    mplier_d = bus.Y;
                    acc_d    = '0;
                    cnt_d    = '0;
                    state_d  = ST_CALC;
                end else begin
                    state_d  = ST_IDLE;
                end
            end
            ST_CALC: begin
                acc_d    = acc_step_s;
                mplier_d = mplier_step_s;
                cnt_d    = cnt_step_s;
                if (finish_s) begin
                    p_d     = result_s;
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_CALC;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        ready_d = (state_d == ST_IDLE);
        done_d  = (state_d == ST_DONE);
    end

    // State and output registers; ready is high out of reset because IDLE is the reset state.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state_q  <= ST_IDLE;
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            cnt_q    <= '0;
            p_q      <= '0;
            ready_q  <= 1'b1;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            cnt_q    <= cnt_d;
            p_q      <= p_d;
            ready_q  <= ready_d;
            done_q   <= done_d;
        end
    end

    assign bus.ready = ready_q;
    assign bus.done  = done_q;
    assign bus.P     = p_q;
endmodule

// File: tb/tb_mult_seq_ctrl.sv
// Scoreboard bench for mult_seq_ctrl; define MULT_EARLY_EXIT_EN to match an early-exit build.
module tb_mult_seq_ctrl;
    localparam int WIDTH = 4;

    typedef struct {
        logic [2*WIDTH-1:0] p;
        int                 lat;
        int                 acc;
    } exp_t;

    logic   clk;
    logic   rst_b;
    int     n_checks;
    int     n_errors;
    int     cyc;
    int     m_phase;
    int     m_left;
    logic [2*WIDTH-1:0] m_p;
    exp_t   sb[$];

    mult_seq_ctrl_if #(.WIDTH(WIDTH)) bus ();

    mult_seq_ctrl #(.WIDTH(WIDTH), .CNT_W(3)) dut (
        .clk   (clk),
        .rst_b (rst_b),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks = n_checks + 1;
        if (obs !== exp) begin
            n_errors = n_errors + 1;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    function automatic int exp_lat(input logic [WIDTH-1:0] y);
`ifdef MULT_EARLY_EXIT_EN
        int l;
        l = 1;
        for (int i = 0; i < WIDTH; i++) begin
            if (y[i]) l = i + 1;
        end
        return l;
`else
        return WIDTH;
`endif
    endfunction

    // Reference timing model: pushes expected product and latency at each accept.
    initial begin
        exp_t e;
        cyc = 0;
        m_phase = 0;
        m_left = 0;
        forever begin
            @(posedge clk or negedge rst_b);
            if (!rst_b) begin
                m_phase = 0;
                m_left = 0;
                sb.delete();
            end else begin
                cyc = cyc + 1;
                case (m_phase)
                    0: begin
                        if (bus.start) begin
                            e.p   = {{WIDTH{1'b0}}, bus.X} * {{WIDTH{1'b0}}, bus.Y};
                            e.lat = exp_lat(bus.Y);
                            e.acc = cyc;
                            sb.push_back(e);
                            m_left = e.lat;
                            m_phase = 1;
                        end
                    end
                    1: begin
                        m_left = m_left - 1;
                        if (m_left == 0) m_phase = 2;
                    end
                    default: m_phase = 0;
                endcase
            end
        end
    end

    // Output checker on the falling edge.
    initial begin
        exp_t e;
        m_p = '0;
        forever begin
            @(negedge clk);
            if (!rst_b) begin
                m_p = '0;
            end else if (bus.done) begin
                if (sb.size() == 0) begin
                    chk("spurious_done", 32'd1, 32'd0);
                end else begin
                    e = sb.pop_front();
                    chk("product", 32'(bus.P), 32'(e.p));
                    chk("latency", 32'(cyc - e.acc), 32'(e.lat));
                    m_p = e.p;
                end
            end
            chk("ready", 32'(bus.ready), 32'(m_phase == 0));
            chk("done", 32'(bus.done), 32'(m_phase == 2));
            chk("p_hold", 32'(bus.P), 32'(m_p));
        end
    end

    task automatic do_op(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y);
        bus.start = 1'b1;
        bus.X = x;
        bus.Y = y;
        @(negedge clk);
        bus.start = 1'b0;
        bus.X = WIDTH'($urandom);
        bus.Y = WIDTH'($urandom);
        repeat (WIDTH + 1) @(negedge clk);
    endtask

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not complete (cycle %0d)", cyc);
        $fatal(1, "timeout");
    end

    initial begin
        n_checks = 0;
        n_errors = 0;
        rst_b = 1'b0;
        bus.start = 1'b0;
        bus.X = '0;
        bus.Y = '0;
        repeat (3) begin
            @(negedge clk);
            bus.start = 1'($urandom);
            bus.X = WIDTH'($urandom);
            bus.Y = WIDTH'($urandom);
        end
        @(negedge clk);
        bus.start = 1'b0;
        rst_b = 1'b1;
        repeat (3) @(negedge clk);

        do_op(4'd13, 4'd11);
        repeat (2) @(negedge clk);
        do_op(4'd15, 4'd15);
        do_op(4'd0, 4'd9);
        do_op(4'd9, 4'd0);
        do_op(4'd1, 4'd1);
        do_op(4'd6, 4'd0);
        do_op(4'd6, 4'd1);
        do_op(4'd6, 4'b0100);
        do_op(4'd6, 4'b1000);

        for (int i = 0; i < 256; i++) begin
            do_op(WIDTH'(i >> WIDTH), WIDTH'(i));
        end

        for (int i = 0; i < 40; i++) begin
            bus.start = 1'b1;
            bus.X = WIDTH'($urandom);
            bus.Y = WIDTH'($urandom);
            @(negedge clk);
        end
        bus.start = 1'b0;
        repeat (WIDTH + 3) @(negedge clk);

        bus.start = 1'b1;
        bus.X = 4'd7;
        bus.Y = 4'd7;
        @(negedge clk);
        bus.start = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1 rst_b = 1'b0;
        repeat (3) @(negedge clk);
        rst_b = 1'b1;
        repeat (2) @(negedge clk);
        do_op(4'd3, 4'd5);
        repeat (2) @(negedge clk);

        chk("scoreboard_empty", 32'(sb.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
